// File: rtl/ps2_keyboard_hex.sv
// PS/2 keyboard receiver: synchronises the device clock, assembles 11-bit frames,
// queues accepted scan codes in a FIFO and shows the head byte on two 7-segment digits.
module ps2_keyboard_hex #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       sampling,
  output logic [6:0] h1,
  output logic [6:0] h2
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Odd parity over the 8 data bits plus the parity bit must XOR to 1.
  function automatic logic parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  // Active-low segments, bit0=a .. bit6=g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  logic [2:0]  ps2c_sync_q, ps2c_sync_d;
  logic [1:0]  ps2d_sync_q, ps2d_sync_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] frame_q, frame_d;
  logic        sampling_q, sampling_d;
  logic        overflow_q, overflow_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];

  logic        fall_s;
  logic        din_s;
  logic [10:0] frame_s;
  logic        last_s;
  logic        valid_s;
  logic        empty_s;
  logic        full_s;
  logic        pop_s;
  logic        push_s;

  // Edge detect, frame assembly and FIFO control decisions.
  always_comb begin
    fall_s  = ps2c_sync_q[2] & ~ps2c_sync_q[1];
    // Data is taken from its own 2-flop synchroniser; it is stable while ps2_clk is low.
    din_s   = ps2d_sync_q[1];
    frame_s = {din_s, frame_q[10:1]};
    last_s  = fall_s & (bit_cnt_q == 4'd10);
    valid_s = last_s & ~frame_s[0] & frame_s[10] & parity_ok(frame_s[9:1]);
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_s   = ~nextdata_n & ~empty_s;
    push_s  = valid_s & (~full_s | pop_s);
  end

  // Next-state values for every register.
  always_comb begin
    ps2c_sync_d = {ps2c_sync_q[1:0], ps2_clk};
    ps2d_sync_d = {ps2d_sync_q[0], ps2_data};
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    sampling_d  = fall_s;
    overflow_d  = overflow_q | (valid_s & full_s & ~pop_s);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    if (fall_s) begin
      frame_d   = frame_s;
      bit_cnt_d = last_s ? 4'd0 : (bit_cnt_q + 4'd1);
    end else begin
      frame_d   = frame_q;
    end
    if (push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = frame_s[8:1];
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      ps2c_sync_q <= 3'b000;
      ps2d_sync_q <= 2'b00;
      bit_cnt_q   <= 4'd0;
      frame_q     <= 11'd0;
      sampling_q  <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      ps2c_sync_q <= ps2c_sync_d;
      ps2d_sync_q <= ps2d_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      sampling_q  <= sampling_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  // Outputs: head of queue and its hex display.
  always_comb begin
    data     = mem_q[rd_ptr_q[AW-1:0]];
    ready    = ~empty_s;
    overflow = overflow_q;
    sampling = sampling_q;
    h1       = hex_to_seg(data[3:0]);
    h2       = hex_to_seg(data[7:4]);
  end

endmodule

// File: tb/tb_ps2_keyboard_hex.sv
// Self-checking bench for ps2_keyboard_hex: table-driven frames plus directed FIFO corner cases.
module tb_ps2_keyboard_hex;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       sampling;
  logic [6:0] h1;
  logic [6:0] h2;

  ps2_keyboard_hex #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow),
    .sampling(sampling), .h1(h1), .h2(h2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic [6:0] h1;
    logic [6:0] h2;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         samp_cnt = 0;
  logic [7:0] exp_q[$];
  vec_t       vecs[8];

  always @(negedge clk) begin
    if (sampling === 1'b1) samp_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clks(4);
    ps2_clk = 1'b0;
    wait_clks(6);
    ps2_clk = 1'b1;
    wait_clks(6);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    logic par;
    par = (~^b) ^ bad;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
    wait_clks(4);
  endtask

  // Compare the head against the scoreboard, then pulse nextdata_n for one clk.
  task automatic pop_check(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %0h expected an entry", name, data);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'd0, data}, {24'd0, e});
    end
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    clrn = 1'b1;
    wait_clks(3);
    clrn = 1'b0;
    wait_clks(2);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 7'h46, 7'h79};
    vecs[1] = '{8'h1C, 1'b1, 7'h46, 7'h79};
    vecs[2] = '{8'hF0, 1'b0, 7'h40, 7'h0E};
    vecs[3] = '{8'h2A, 1'b0, 7'h08, 7'h24};
    vecs[4] = '{8'h5B, 1'b0, 7'h03, 7'h12};
    vecs[5] = '{8'h36, 1'b1, 7'h02, 7'h30};
    vecs[6] = '{8'hE7, 1'b0, 7'h78, 7'h06};
    vecs[7] = '{8'hD9, 1'b0, 7'h10, 7'h21};

    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    clrn       = 1'b1;
    wait_clks(3);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_sampling", {31'd0, sampling}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_h1", {25'd0, h1}, 32'h40);
    check("rst_h2", {25'd0, h2}, 32'h40);
    clrn = 1'b0;
    wait_clks(2);

    // Single frames, good and bad parity.
    for (int v = 0; v < 8; v++) begin
      samp_cnt = 0;
      send_frame(vecs[v].code, vecs[v].bad_par);
      check($sformatf("v%0d_samples", v), samp_cnt, 32'd11);
      if (vecs[v].bad_par) begin
        check($sformatf("v%0d_badpar_ready", v), {31'd0, ready}, 32'd0);
      end else begin
        exp_q.push_back(vecs[v].code);
        check($sformatf("v%0d_ready", v), {31'd0, ready}, 32'd1);
        check($sformatf("v%0d_h1", v), {25'd0, h1}, {25'd0, vecs[v].h1});
        check($sformatf("v%0d_h2", v), {25'd0, h2}, {25'd0, vecs[v].h2});
        pop_check($sformatf("v%0d_data", v));
        check($sformatf("v%0d_empty", v), {31'd0, ready}, 32'd0);
      end
    end

    // Three queued bytes popped one at a time.
    send_frame(8'h1C, 1'b0); exp_q.push_back(8'h1C);
    send_frame(8'hF0, 1'b0); exp_q.push_back(8'hF0);
    send_frame(8'h1C, 1'b0); exp_q.push_back(8'h1C);
    pop_check("seq_pop0");
    pop_check("seq_pop1");
    check("seq_ready_mid", {31'd0, ready}, 32'd1);
    pop_check("seq_pop2");
    check("seq_ready_end", {31'd0, ready}, 32'd0);
    check("no_overflow_yet", {31'd0, overflow}, 32'd0);

    // Nine frames into an 8-deep FIFO: ninth is lost.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_frame(8'h10 + 8'(i * 7), 1'b0);
      if (i < 8) exp_q.push_back(8'h10 + 8'(i * 7));
    end
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_ready", {31'd0, ready}, 32'd1);
    for (int i = 0; i < 8; i++) pop_check($sformatf("ovf_pop%0d", i));
    check("ovf_empty", {31'd0, ready}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset in the middle of a frame.
    do_reset();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    clrn = 1'b1;
    wait_clks(3);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    clrn = 1'b0;
    wait_clks(3);
    send_frame(8'h2A, 1'b0); exp_q.push_back(8'h2A);
    check("midrst_ready_after", {31'd0, ready}, 32'd1);
    pop_check("midrst_data");
    check("midrst_no_spurious", {31'd0, ready}, 32'd0);

    // Hold nextdata_n low: one pop per cycle, then nothing.
    send_frame(8'h31, 1'b0);
    send_frame(8'h32, 1'b0);
    send_frame(8'h33, 1'b0);
    nextdata_n = 1'b0;
    check("hold_d0", {24'd0, data}, 32'h31);
    @(negedge clk);
    check("hold_d1", {24'd0, data}, 32'h32);
    @(negedge clk);
    check("hold_d2", {24'd0, data}, 32'h33);
    @(negedge clk);
    check("hold_empty", {31'd0, ready}, 32'd0);
    wait_clks(3);
    check("hold_still_empty", {31'd0, ready}, 32'd0);
    nextdata_n = 1'b1;
    wait_clks(1);
    send_frame(8'h44, 1'b0); exp_q.push_back(8'h44);
    check("hold_after_ready", {31'd0, ready}, 32'd1);
    pop_check("hold_after_data");
    check("hold_after_empty", {31'd0, ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
